// File: rtl/per2axi_txn_limiter.sv
// Purpose: limits outstanding per2axi write/read transactions and provides a drain handshake for power control.
// Latency: admission (req_ready_o) is combinational from registered state; counts, busy, err and drain_ack update one cycle after the event.
// Backpressure: req_ready_o drops when a direction is at its limit, while draining/halted, or in reset; retires never raise ready in the same cycle.
// Optional feature: define PER2AXI_TXN_ORDER_EN to admit a write only with no reads in flight, and a read only with no writes in flight.
module per2axi_txn_limiter #(
    parameter int unsigned MAX_WR_OUTSTANDING = 4,
    parameter int unsigned MAX_RD_OUTSTANDING = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    input  logic       req_we_i,
    output logic       req_ready_o,
    input  logic       b_done_i,
    input  logic       r_done_i,
    input  logic       drain_req_i,
    output logic       drain_ack_o,
    output logic       busy_o,
    output logic [3:0] wr_count_o,
    output logic [3:0] rd_count_o,
    output logic       err_o
);

    localparam logic [3:0] WR_MAX = 4'(MAX_WR_OUTSTANDING);
    localparam logic [3:0] RD_MAX = 4'(MAX_RD_OUTSTANDING);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] wr_cnt_q, wr_cnt_d;
    logic [3:0] rd_cnt_q, rd_cnt_d;
    logic       err_q, err_d;
    logic       ack_q, ack_d;

    logic       wr_ok, rd_ok;
    logic       wr_issue, rd_issue;
    logic       wr_retire, rd_retire;

    // Admission: only registered state plus the request's direction and drain level decide ready.
    always_comb begin
        wr_ok = (state_q == RUN) & ~drain_req_i & (wr_cnt_q < WR_MAX);
        rd_ok = (state_q == RUN) & ~drain_req_i & (rd_cnt_q < RD_MAX);
`ifdef PER2AXI_TXN_ORDER_EN
        // Peripherals without ordered response paths need one direction drained before the other issues.
        wr_ok = wr_ok & (rd_cnt_q == 4'd0);
        rd_ok = rd_ok & (wr_cnt_q == 4'd0);
`else
        wr_ok = wr_ok;
        rd_ok = rd_ok;
`endif
        req_ready_o = ~rst_i & (req_we_i ? wr_ok : rd_ok);
    end

    // Next-state: counts move by issue minus retire; a retire with the count at zero is dropped and flagged.
    always_comb begin
        wr_issue  = req_valid_i & req_ready_o & req_we_i;
        rd_issue  = req_valid_i & req_ready_o & ~req_we_i;
        wr_retire = b_done_i & (wr_cnt_q != 4'd0);
        rd_retire = r_done_i & (rd_cnt_q != 4'd0);

        wr_cnt_d = wr_cnt_q + {3'd0, wr_issue} - {3'd0, wr_retire};
        rd_cnt_d = rd_cnt_q + {3'd0, rd_issue} - {3'd0, rd_retire};

        err_d = err_q
              | (b_done_i & (wr_cnt_q == 4'd0))
              | (r_done_i & (rd_cnt_q == 4'd0));

        state_d = state_q;
        case (state_q)
            RUN:   if (drain_req_i) state_d = DRAIN;
            DRAIN: begin
                if (!drain_req_i) begin
                    state_d = RUN;
                end else if ((wr_cnt_q == 4'd0) && (rd_cnt_q == 4'd0)) begin
                    state_d = HALT;
                end
            end
            HALT:  if (!drain_req_i) state_d = RUN;
            default: state_d = RUN;
        endcase

        ack_d = (state_d == HALT);
    end

    // State registers, including the FSM and its registered acknowledge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            wr_cnt_q <= 4'd0;
            rd_cnt_q <= 4'd0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
        end
    end

    assign drain_ack_o = ack_q;
    assign busy_o      = (wr_cnt_q != 4'd0) | (rd_cnt_q != 4'd0);
    assign wr_count_o  = wr_cnt_q;
    assign rd_count_o  = rd_cnt_q;
    assign err_o       = err_q;

endmodule
